// File: rtl/mul_unit.sv
// Shift-add MULT/MULTU multiplier for the HI/LO unit: 32 add/shift steps plus one sign-fix cycle, done 33 edges after start.
// No backpressure: start is only sampled in IDLE and ignored while busy; done is a one-cycle pulse and dataOut holds until the next one.
module mul_unit #(
    parameter int          WIDTH    = 32,
    parameter logic [5:0]  MULT_FN  = 6'b011000,
    parameter logic [5:0]  MULTU_FN = 6'b011001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [5:0]           Signal,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   dataOut
);

    localparam int             CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [2*WIDTH-1:0]    r_prod;
    logic [WIDTH-1:0]      r_mcand;
    logic                  r_neg;
    logic [CNT_W-1:0]      r_count;
    logic                  r_busy;
    logic                  r_done;
    logic [2*WIDTH-1:0]    r_out;

    logic                  w_is_mult;
    logic                  w_is_multu;
    logic                  w_accept;
    logic [WIDTH-1:0]      w_abs_a;
    logic [WIDTH-1:0]      w_abs_b;
    logic [WIDTH:0]        w_upper;
    logic [2*WIDTH-1:0]    w_fixed;

    assign w_is_mult  = (Signal == MULT_FN);
    assign w_is_multu = (Signal == MULTU_FN);
    assign w_accept   = (r_state == S_IDLE) && start && (w_is_mult || w_is_multu);

    // Magnitudes are taken as unsigned, so the most negative value maps onto itself correctly.
    assign w_abs_a = dataA[WIDTH-1] ? (~dataA + 1'b1) : dataA;
    assign w_abs_b = dataB[WIDTH-1] ? (~dataB + 1'b1) : dataB;

    // 33-bit upper half keeps the carry that the right shift brings back into bit 63.
    assign w_upper = r_prod[0] ? ({1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand})
                               : {1'b0, r_prod[2*WIDTH-1:WIDTH]};

    assign w_fixed = r_neg ? (~r_prod + 1'b1) : r_prod;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_CALC;
            S_CALC:  if (r_count == LAST_STEP) w_next_state = S_FIX;
            S_FIX:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prod  <= '0;
            r_mcand <= '0;
            r_neg   <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_out   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand <= w_is_mult ? w_abs_a : dataA;
                        r_prod  <= {{WIDTH{1'b0}}, (w_is_mult ? w_abs_b : dataB)};
                        r_neg   <= w_is_mult && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_prod  <= {w_upper, r_prod[WIDTH-1:1]};
                    r_count <= r_count + 1'b1;
                end
                S_FIX: begin
                    r_out  <= w_fixed;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign dataOut = r_out;

endmodule

// File: tb/tb_mul_unit.sv
// Bench for mul_unit: vector table, hand-written handshake corner cases, and random ops against a plain-arithmetic model.
module tb_mul_unit;

    localparam logic [5:0] MULT_FN  = 6'b011000;
    localparam logic [5:0] MULTU_FN = 6'b011001;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  Signal;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic [63:0] dataOut;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    typedef struct {
        string       name;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    mul_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .Signal  (Signal),
        .dataA   (dataA),
        .dataB   (dataB),
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 400000");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        if (fn == MULT_FN) return 64'(sa * sb);
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Caller sits just after a rising edge; start is sampled on the next edge.
    task automatic launch(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        Signal = fn;
        dataA  = a;
        dataB  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            lat++;
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (lat >= 60) break;
        end
    endtask

    task automatic run_op(input string name, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int lat;
        bit ok;
        logic [63:0] prev;
        prev = dataOut;
        launch(fn, a, b);
        chk({name, "_busy_rise"}, {63'b0, busy}, 64'd1);
        wait_done(lat, ok);
        chk({name, "_latency"}, 64'(lat), 64'd33);
        chk({name, "_busy_held"}, {63'b0, ok}, 64'd1);
        chk({name, "_busy_drop"}, {63'b0, busy}, 64'd0);
        chk({name, "_result"}, dataOut, exp);
        if (lat < 33) chk({name, "_out_held"}, prev, exp);
        @(posedge clk);
        #1;
        chk({name, "_done_pulse"}, {63'b0, done}, 64'd0);
        chk({name, "_out_stable"}, dataOut, exp);
    endtask

    initial begin
        vec_t vecs[$];
        int   lat;
        bit   ok;
        int   dc0;

        vecs.push_back('{"multu_max",   MULTU_FN, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001});
        vecs.push_back('{"mult_m3x7",   MULT_FN,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB});
        vecs.push_back('{"mult_m3xm7",  MULT_FN,  32'hFFFF_FFFD, 32'hFFFF_FFF9, 64'h0000_0000_0000_0015});
        vecs.push_back('{"mult_minmin", MULT_FN,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000});
        vecs.push_back('{"mult_minx1",  MULT_FN,  32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000});
        vecs.push_back('{"mult_0xneg",  MULT_FN,  32'd0,         32'hFFFF_FFFF, 64'h0});
        vecs.push_back('{"mult_negx0",  MULT_FN,  32'h8000_0001, 32'd0,         64'h0});
        vecs.push_back('{"mult_maxpos", MULT_FN,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001});
        vecs.push_back('{"multu_big",   MULTU_FN, 32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000});

        reset = 1'b1; start = 1'b0; Signal = '0; dataA = '0; dataB = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_out", dataOut, 64'd0);
        reset = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Start while busy, with operand changes mid-operation: must be ignored.
        dc0 = done_cnt;
        launch(MULTU_FN, 32'd5, 32'd6);
        repeat (9) begin @(posedge clk); #1; end
        start = 1'b1; Signal = MULTU_FN; dataA = 32'd2; dataB = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; dataA = 32'd99;
        wait_done(lat, ok);
        chk("ignore_latency", 64'(lat), 64'd23);
        chk("ignore_result", dataOut, 64'd30);
        repeat (40) begin @(posedge clk); #1; end
        chk("ignore_one_done", 64'(done_cnt - dc0), 64'd1);
        chk("ignore_idle_busy", {63'b0, busy}, 64'd0);

        // Reset mid-operation aborts with no done.
        dc0 = done_cnt;
        launch(MULTU_FN, 32'd12345, 32'd678);
        repeat (14) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_out", dataOut, 64'd0);
        repeat (40) begin @(posedge clk); #1; end
        chk("abort_no_done", 64'(done_cnt - dc0), 64'd0);
        run_op("after_abort", MULTU_FN, 32'd12345, 32'd678, 64'd8369910);

        // Unsupported funct code is ignored.
        dc0 = done_cnt;
        launch(6'b011011, 32'd3, 32'd4);
        chk("badfn_busy", {63'b0, busy}, 64'd0);
        repeat (40) begin @(posedge clk); #1; end
        chk("badfn_no_done", 64'(done_cnt - dc0), 64'd0);
        chk("badfn_out", dataOut, 64'd8369910);

        // Back-to-back: second start asserted in the done cycle of the first.
        launch(MULTU_FN, 32'd7, 32'd9);
        wait_done(lat, ok);
        chk("b2b_first_latency", 64'(lat), 64'd33);
        chk("b2b_first_result", dataOut, 64'd63);
        launch(MULTU_FN, 32'd3, 32'd4);
        chk("b2b_second_busy", {63'b0, busy}, 64'd1);
        wait_done(lat, ok);
        chk("b2b_second_latency", 64'(lat), 64'd33);
        chk("b2b_second_busy_held", {63'b0, ok}, 64'd1);
        chk("b2b_second_result", dataOut, 64'd12);
        @(posedge clk); #1;

        for (int k = 0; k < 16; k++) begin
            logic [5:0]  fn;
            logic [31:0] a, b;
            fn = ($urandom_range(0, 1) == 0) ? MULT_FN : MULTU_FN;
            a  = $urandom;
            b  = $urandom;
            if (k == 0) a = 32'h8000_0000;
            if (k == 1) b = 32'hFFFF_FFFF;
            run_op($sformatf("rand%0d", k), fn, a, b, model(fn, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
